// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 power-up and register configuration sequencer.
// Holds the one-hot state encoding, the SCCB write ID and the default timing constants.
package ov7670_pkg;

  localparam logic [7:0] SCCB_WR_ID  = 8'h42;
  localparam int         CNT_W       = 18;
  localparam int         DEF_CFG_LEN = 4;
  localparam int         DEF_PWR_DLY = 150000;
  localparam int         DEF_GAP_DLY = 1000;
  localparam int         DEF_ACK_TMO = 65535;

  typedef enum logic [6:0] {
    PWR_HOLD   = 7'b000_0001,
    RST_SETTLE = 7'b000_0010,
    LOAD       = 7'b000_0100,
    WRITE      = 7'b000_1000,
    GAP        = 7'b001_0000,
    DONE       = 7'b010_0000,
    ERR        = 7'b100_0000
  } state_t;

  function automatic logic is_busy(input state_t s);
    logic b;
    case (s)
      DONE, ERR: b = 1'b0;
      default:   b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ov7670_cfg_seq_if.sv
// Write request channel between the configuration sequencer and the SCCB writer.
// The sequencer is the master; the writer answers with a one-cycle wr_done pulse.
interface ov7670_cfg_seq_if;

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_done;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_done
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_done
  );

endinterface

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register configuration table: combinational lookup of {reg_addr, reg_data}.
// Entry 0 issues a COM7 soft reset; unused indices return 16'hFFFF.
module ov7670_cfg_rom
  import ov7670_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  // Table lookup
  always_comb begin
    entry = 16'hFFFF;
    case (idx)
      8'd0:    entry = 16'h1280;
      8'd1:    entry = 16'h1101;
      8'd2:    entry = 16'h1204;
      8'd3:    entry = 16'h40D0;
      8'd4:    entry = 16'h8C00;
      8'd5:    entry = 16'h3A04;
      8'd6:    entry = 16'h1418;
      8'd7:    entry = 16'h4FB3;
      8'd8:    entry = 16'h50B3;
      8'd9:    entry = 16'h5100;
      8'd10:   entry = 16'h523D;
      8'd11:   entry = 16'h53A7;
      default: entry = 16'hFFFF;
    endcase
  end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// OV7670 camera bring-up: power-down/reset sequencing, then walks the register table
// through the SCCB writer, one write per table entry with an idle gap in between.
module ov7670_cfg_seq
  import ov7670_pkg::*;
#(
  parameter int CFG_LEN = DEF_CFG_LEN,
  parameter int PWR_DLY = DEF_PWR_DLY,
  parameter int GAP_DLY = DEF_GAP_DLY,
  parameter int ACK_TMO = DEF_ACK_TMO
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             start,
  ov7670_cfg_seq_if.master wr_bus,
  output logic             cam_pwdn,
  output logic             cam_rst_n,
  output logic [7:0]       cfg_idx,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_DLY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       IDX_LAST = 8'(CFG_LEN - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       cfg_idx_r;
  logic [7:0]       cfg_idx_nxt_s;
  logic [15:0]      rom_entry_s;
  logic [7:0]       wr_addr_r;
  logic [7:0]       wr_data_r;
  logic             wr_en_r;
  logic             cam_pwdn_r;
  logic             cam_rst_n_r;
  logic             busy_r;
  logic             cfg_done_r;
  logic             cfg_err_r;

  ov7670_cfg_rom u_rom (
    .idx   (cfg_idx_r),
    .entry (rom_entry_s)
  );

  // Next-state, table index and shared delay counter decode
  always_comb begin
    state_nxt_s   = state_r;
    cfg_idx_nxt_s = cfg_idx_r;
    cnt_nxt_s     = cnt_r;
    case (state_r)
      PWR_HOLD: begin
        if (cnt_r == PWR_LAST) state_nxt_s = RST_SETTLE;
        else                   state_nxt_s = PWR_HOLD;
      end
      RST_SETTLE: begin
        if (cnt_r == PWR_LAST) state_nxt_s = LOAD;
        else                   state_nxt_s = RST_SETTLE;
      end
      LOAD: begin
        state_nxt_s = WRITE;
      end
      WRITE: begin
        // An ack on the timeout cycle still wins over the timeout.
        if (wr_bus.wr_done) begin
          if (cfg_idx_r == IDX_LAST) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s   = GAP;
            cfg_idx_nxt_s = cfg_idx_r + 8'd1;
          end
        end else if (cnt_r == ACK_LAST) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) state_nxt_s = LOAD;
        else                   state_nxt_s = GAP;
      end
      DONE, ERR: begin
        if (start) begin
          state_nxt_s   = PWR_HOLD;
          cfg_idx_nxt_s = 8'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s   = PWR_HOLD;
        cfg_idx_nxt_s = 8'd0;
      end
    endcase

    if (state_nxt_s != state_r) cnt_nxt_s = {CNT_W{1'b0}};
    else if (cnt_r == CNT_MAX)  cnt_nxt_s = cnt_r;
    else                        cnt_nxt_s = cnt_r + CNT_ONE;
  end

  // State, counter and index registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= PWR_HOLD;
      cnt_r     <= {CNT_W{1'b0}};
      cfg_idx_r <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      cfg_idx_r <= cfg_idx_nxt_s;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r     <= 1'b0;
      wr_addr_r   <= 8'd0;
      wr_data_r   <= 8'd0;
      cam_pwdn_r  <= 1'b1;
      cam_rst_n_r <= 1'b0;
      busy_r      <= 1'b1;
      cfg_done_r  <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      wr_en_r     <= (state_r == WRITE) && (state_nxt_s == WRITE);
      if (state_r == LOAD) begin
        wr_addr_r <= rom_entry_s[15:8];
        wr_data_r <= rom_entry_s[7:0];
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
      cam_pwdn_r  <= (state_nxt_s == PWR_HOLD);
      cam_rst_n_r <= (state_nxt_s != PWR_HOLD);
      busy_r      <= is_busy(state_nxt_s);
      cfg_done_r  <= (state_nxt_s == DONE);
      cfg_err_r   <= (state_nxt_s == ERR);
    end
  end

  assign wr_bus.wr_en   = wr_en_r;
  assign wr_bus.wr_addr = wr_addr_r;
  assign wr_bus.wr_data = wr_data_r;
  assign cam_pwdn       = cam_pwdn_r;
  assign cam_rst_n      = cam_rst_n_r;
  assign cfg_idx        = cfg_idx_r;
  assign busy           = busy_r;
  assign cfg_done       = cfg_done_r;
  assign cfg_err        = cfg_err_r;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Self-checking bench for ov7670_cfg_seq: expected waveforms come from an event timeline
// (rise/fall cycle of every write burst) derived from the phase lengths and ack delays.
module tb_ov7670_cfg_seq;

  logic       sclk;
  logic       rst_n;
  logic       start;
  logic       spur_done;
  logic       wr_done_m;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic [7:0] cfg_idx;
  logic       busy;
  logic       cfg_done;
  logic       cfg_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ack_dly [4];
  int noack_idx;
  logic [15:0] exp_rom [4];

  ov7670_cfg_seq_if bus ();

  assign bus.wr_done = wr_done_m | spur_done;

  ov7670_cfg_seq #(
    .CFG_LEN (4),
    .PWR_DLY (10),
    .GAP_DLY (3),
    .ACK_TMO (50)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_bus    (bus),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .cfg_idx   (cfg_idx),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // SCCB writer model: pulses wr_done during the Nth cycle of a wr_en burst
  initial begin
    int en_cnt;
    en_cnt    = 0;
    wr_done_m = 1'b0;
    forever begin
      @(posedge sclk);
      #2;
      if (bus.wr_en) en_cnt++;
      else           en_cnt = 0;
      wr_done_m = bus.wr_en && (en_cnt == ack_dly[cfg_idx[1:0]]) &&
                  (int'(cfg_idx) != noack_idx);
    end
  end

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic chk8(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic chk_reset_vals(input int k);
    chk1("rst_pwdn",  k, cam_pwdn,   1'b1);
    chk1("rst_camrst", k, cam_rst_n, 1'b0);
    chk1("rst_wr_en", k, bus.wr_en,  1'b0);
    chk8("rst_addr",  k, bus.wr_addr, 8'h00);
    chk8("rst_data",  k, bus.wr_data, 8'h00);
    chk8("rst_idx",   k, cfg_idx,    8'h00);
    chk1("rst_busy",  k, busy,       1'b1);
    chk1("rst_done",  k, cfg_done,   1'b0);
    chk1("rst_err",   k, cfg_err,    1'b0);
  endtask

  task automatic pulse_start();
    @(negedge sclk);
    start = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    start = 1'b0;
  endtask

  // Walks one sequence from cycle 0 (power-up entry), checking every cycle against the timeline.
  // start_off/spur_off place a stray pulse in the first/second gap; rst_off resets inside write 1.
  task automatic run_seq(input int start_off, input int spur_off, input int rst_off);
    int rise [4];
    int fall [4];
    int nent, end_k, start_at, spur_at, rst_at, exp_idx, cur;
    logic exp_en, fin;
    nent = (noack_idx >= 0) ? noack_idx + 1 : 4;
    for (int i = 0; i < nent; i++) begin
      rise[i] = (i == 0) ? 22 : fall[i-1] + 5;
      fall[i] = rise[i] + ((i == noack_idx) ? 49 : ack_dly[i]);
    end
    end_k    = fall[nent-1];
    start_at = (start_off >= 0) ? fall[0] + start_off : -1;
    spur_at  = (spur_off >= 0 && nent > 1) ? fall[1] + spur_off : -1;
    rst_at   = (rst_off >= 0 && nent > 1) ? rise[1] + rst_off : -1;
    for (int k = 0; k <= end_k + 4; k++) begin
      if (k > 0) begin
        @(posedge sclk);
        @(negedge sclk);
      end
      exp_en  = 1'b0;
      exp_idx = 0;
      cur     = -1;
      for (int i = 0; i < nent; i++) begin
        if (k >= rise[i] && k < fall[i]) begin
          exp_en = 1'b1;
          cur    = i;
        end
        if (i < nent - 1 && k >= fall[i]) exp_idx++;
      end
      fin = (k >= end_k);
      chk1("wr_en",     k, bus.wr_en, exp_en);
      chk1("cam_pwdn",  k, cam_pwdn,  k < 10);
      chk1("cam_rst_n", k, cam_rst_n, k >= 10);
      chk8("cfg_idx",   k, cfg_idx,   8'(exp_idx));
      chk1("busy",      k, busy,      !fin);
      chk1("cfg_done",  k, cfg_done,  fin && (noack_idx < 0));
      chk1("cfg_err",   k, cfg_err,   fin && (noack_idx >= 0));
      if (cur >= 0) begin
        chk8("wr_addr", k, bus.wr_addr, exp_rom[cur][15:8]);
        chk8("wr_data", k, bus.wr_data, exp_rom[cur][7:0]);
      end
      start     = (k == start_at);
      spur_done = (k == spur_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals(k);
        start     = 1'b0;
        spur_done = 1'b0;
        return;
      end
    end
    start     = 1'b0;
    spur_done = 1'b0;
  endtask

  task automatic rand_delays();
    for (int i = 0; i < 4; i++) ack_dly[i] = int'($urandom_range(1, 49));
  endtask

  initial begin
    exp_rom[0] = 16'h1280;
    exp_rom[1] = 16'h1101;
    exp_rom[2] = 16'h1204;
    exp_rom[3] = 16'h40D0;
    rst_n      = 1'b0;
    start      = 1'b0;
    spur_done  = 1'b0;
    noack_idx  = -1;
    for (int i = 0; i < 4; i++) ack_dly[i] = 20;

    repeat (3) @(negedge sclk);
    chk_reset_vals(0);
    rst_n = 1'b1;

    // Nominal bring-up, writer acks 20 cycles into each burst
    run_seq(-1, -1, -1);

    // Random ack delays; start in a gap and wr_done outside WRITE are both ignored
    rand_delays();
    pulse_start();
    run_seq(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);

    // Entry 2 never acked: timeout after 50 cycles in WRITE
    rand_delays();
    noack_idx = 2;
    pulse_start();
    run_seq(-1, -1, -1);

    // Restart from ERR; acks landing exactly on the timeout cycle count as success
    rand_delays();
    noack_idx  = -1;
    ack_dly[1] = 49;
    ack_dly[3] = 49;
    pulse_start();
    run_seq(int'($urandom_range(0, 2)), -1, -1);

    // Reset in the middle of write 1, then a clean rerun after release
    rand_delays();
    ack_dly[1] = 30;
    pulse_start();
    run_seq(-1, -1, int'($urandom_range(2, 5)));
    repeat (2) @(negedge sclk);
    chk_reset_vals(-1);
    rand_delays();
    rst_n = 1'b1;
    run_seq(-1, -1, -1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
